uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_defs.svh | 24 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_defs.svh
// Shared UART definitions: data/baud/frame widths and receiver state encoding.
// Used by both the receiver and the transmitter of the UART pair.
// No logic; constants and types only.
`ifndef UART_DEFS_SVH
`define UART_DEFS_SVH

package uart_pkg;

    localparam int UART_DATA_SIZE       = 8;
    localparam int UART_BAUD_DIV_SIZE   = 16;
    localparam int UART_FRAME_BIT_COUNT = 4;

    // Receiver FSM encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] type_uart_rx_states_e;

    localparam type_uart_rx_states_e UART_RX_IDLE      = 3'd0;
    localparam type_uart_rx_states_e UART_RX_START     = 3'd1;
    localparam type_uart_rx_states_e UART_RX_DATA      = 3'd2;
    localparam type_uart_rx_states_e UART_RX_STOP      = 3'd3;
    localparam type_uart_rx_states_e UART_RX_WAIT_IDLE = 3'd4;

endpackage

`endif

// File: rtl/uart_rx.sv
// UART receiver: 8N1/8N2 frames, mid-bit sampling with a programmable divider.
// Latency: valid_o rises 1 cycle after the last stop-bit sample (+2 sync cycles).
// Backpressure: one-byte holding register; a byte completing while it is full
// and not being consumed is dropped and overrun_o pulses.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   rx_pin_i        serial line (async, idle high)
//   baud_div_i      clk cycles per bit (>= 4), sampled at every reload
//   two_stop_bits   1: check two stop bits, 0: one
//   ready_i         consumer takes rx_data_o when valid_o is high
//   rx_data_o       received byte, stable while valid_o
//   valid_o         rx_data_o holds an unconsumed byte
//   frame_err_o     1-cycle pulse: a stop bit sampled low
//   overrun_o       1-cycle pulse: byte dropped because holding reg was full
`include "uart_defs.svh"

module uart_rx
    import uart_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_pin_i,
    input  logic [UART_BAUD_DIV_SIZE-1:0] baud_div_i,
    input  logic                          two_stop_bits,
    input  logic                          ready_i,
    output logic [UART_DATA_SIZE-1:0]     rx_data_o,
    output logic                          valid_o,
    output logic                          frame_err_o,
    output logic                          overrun_o
);

    logic                            rx_meta;
    logic                            rx_sync;
    type_uart_rx_states_e            state;
    logic [UART_BAUD_DIV_SIZE-1:0]   sample_cnt;
    logic [UART_FRAME_BIT_COUNT-1:0] bit_cnt;
    logic [UART_DATA_SIZE-1:0]       shifter;

    logic cnt_hit;
    logic last_stop;
    logic byte_done;
    logic stop_bad;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_pin_i;
            rx_sync <= rx_meta;
        end
    end

    assign cnt_hit   = (sample_cnt == UART_BAUD_DIV_SIZE'(1));
    // In STOP, bit_cnt counts stop bits already sampled high.
    assign last_stop = !two_stop_bits || (bit_cnt == UART_FRAME_BIT_COUNT'(1));
    assign byte_done = (state == UART_RX_STOP) && cnt_hit && rx_sync && last_stop;
    assign stop_bad  = (state == UART_RX_STOP) && cnt_hit && !rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UART_RX_IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shifter    <= '0;
        end else begin
            case (state)
                UART_RX_IDLE: begin
                    // Half a bit period lands the first sample mid start bit.
                    if (!rx_sync) begin
                        sample_cnt <= baud_div_i >> 1;
                        state      <= UART_RX_START;
                    end
                end
                UART_RX_START: begin
                    if (cnt_hit) begin
                        if (!rx_sync) begin
                            sample_cnt <= baud_div_i;
                            bit_cnt    <= '0;
                            state      <= UART_RX_DATA;
                        end else begin
                            state <= UART_RX_IDLE;
                        end
                    end else begin
                        sample_cnt <= sample_cnt - 1'b1;
                    end
                end
                UART_RX_DATA: begin
                    if (cnt_hit) begin
                        shifter    <= {rx_sync, shifter[UART_DATA_SIZE-1:1]};
                        sample_cnt <= baud_div_i;
                        if (bit_cnt == UART_FRAME_BIT_COUNT'(UART_DATA_SIZE - 1)) begin
                            bit_cnt <= '0;
                            state   <= UART_RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        sample_cnt <= sample_cnt - 1'b1;
                    end
                end
                UART_RX_STOP: begin
                    if (cnt_hit) begin
                        if (!rx_sync) begin
                            state <= UART_RX_WAIT_IDLE;
                        end else if (last_stop) begin
                            state <= UART_RX_IDLE;
                        end else begin
                            bit_cnt    <= bit_cnt + 1'b1;
                            sample_cnt <= baud_div_i;
                        end
                    end else begin
                        sample_cnt <= sample_cnt - 1'b1;
                    end
                end
                UART_RX_WAIT_IDLE: begin
                    // Ride out a break: no new frame until the line returns high.
                    if (rx_sync) begin
                        state <= UART_RX_IDLE;
                    end
                end
                default: state <= UART_RX_IDLE;
            endcase
        end
    end

    // Holding register: a new byte is accepted only into an empty or
    // simultaneously drained slot, so rx_data_o never changes under valid_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_o   <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= stop_bad;
            overrun_o   <= byte_done && valid_o && !ready_i;
            if (byte_done && (!valid_o || ready_i)) begin
                rx_data_o <= shifter;
                valid_o   <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic        clk;
    logic        rst_n;
    logic        rx_pin_i;
    logic [15:0] baud_div_i;
    logic        two_stop_bits;
    logic        ready_i;
    logic [7:0]  rx_data_o;
    logic        valid_o;
    logic        frame_err_o;
    logic        overrun_o;

    uart_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_pin_i      (rx_pin_i),
        .baud_div_i    (baud_div_i),
        .two_stop_bits (two_stop_bits),
        .ready_i       (ready_i),
        .rx_data_o     (rx_data_o),
        .valid_o       (valid_o),
        .frame_err_o   (frame_err_o),
        .overrun_o     (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Output monitor: cumulative counts, sampled on the falling edge.
    int         n_valid = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (valid_o) n_valid = n_valid + 1;
        if (valid_o && ready_i) last_data = rx_data_o;
        if (frame_err_o) n_ferr = n_ferr + 1;
        if (overrun_o) n_ovr = n_ovr + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v, input int n);
        rx_pin_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        send_bit(1'b1, n);
    endtask

    // stop_low[0]/[1]: drive first/second stop bit low.
    task automatic send_frame(input logic [7:0] d, input int baud, input logic two,
                              input logic [1:0] stop_low);
        baud_div_i    = 16'(baud);
        two_stop_bits = two;
        send_bit(1'b0, baud);
        for (int i = 0; i < 8; i++) send_bit(d[i], baud);
        send_bit(!stop_low[0], baud);
        if (two) send_bit(!stop_low[1], baud);
        rx_pin_i = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        int         baud;
        logic       two;
        logic [1:0] stop_low;
        int         brk;        // cycles of line held low after the frame
        int         pre;        // idle cycles before the frame
        int         exp_valid;  // valid_o-high cycles (ready_i=1)
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    int v0, f0, o0;

    initial begin
        vecs[0] = '{8'hA5, 16, 1'b0, 2'b00, 0,  4, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 8,  1'b1, 2'b00, 0,  0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 8,  1'b1, 2'b00, 0,  0, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 8,  1'b1, 2'b00, 0,  0, 1, 0, 8'h3C};
        vecs[4] = '{8'h55, 16, 1'b0, 2'b01, 40, 4, 0, 1, 8'h00};
        vecs[5] = '{8'h12, 16, 1'b0, 2'b00, 0,  4, 1, 0, 8'h12};
        vecs[6] = '{8'hC3, 4,  1'b1, 2'b00, 0,  2, 1, 0, 8'hC3};
        vecs[7] = '{8'h7E, 5,  1'b0, 2'b00, 0,  2, 1, 0, 8'h7E};
        vecs[8] = '{8'h96, 8,  1'b1, 2'b10, 0,  2, 0, 1, 8'h00};
        vecs[9] = '{8'h81, 8,  1'b1, 2'b00, 0,  4, 1, 0, 8'h81};

        rst_n         = 1'b0;
        rx_pin_i      = 1'b1;
        baud_div_i    = 16'd16;
        two_stop_bits = 1'b0;
        ready_i       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset rx_data_o", 32'(rx_data_o), 32'h0);
        check("reset valid_o", 32'(valid_o), 32'h0);
        check("reset frame_err_o", 32'(frame_err_o), 32'h0);
        check("reset overrun_o", 32'(overrun_o), 32'h0);
        rst_n = 1'b1;
        idle(4);

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            idle(vecs[i].pre);
            v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
            send_frame(vecs[i].data, vecs[i].baud, vecs[i].two, vecs[i].stop_low);
            if (vecs[i].brk > 0) send_bit(1'b0, vecs[i].brk);
            idle(4);
            check($sformatf("vec%0d valid cycles", i), 32'(n_valid - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d frame_err pulses", i), 32'(n_ferr - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d overrun pulses", i), 32'(n_ovr - o0), 32'h0);
            if (vecs[i].exp_valid > 0)
                check($sformatf("vec%0d data", i), 32'(last_data), 32'(vecs[i].exp_data));
        end

        // Start-bit glitch: 4 low cycles at divider 16 must be ignored.
        baud_div_i = 16'd16;
        v0 = n_valid; f0 = n_ferr;
        send_bit(1'b0, 4);
        idle(40);
        check("glitch valid cycles", 32'(n_valid - v0), 32'h0);
        check("glitch frame_err pulses", 32'(n_ferr - f0), 32'h0);
        send_frame(8'h5A, 16, 1'b0, 2'b00);
        idle(4);
        check("after glitch valid cycles", 32'(n_valid - v0), 32'h1);
        check("after glitch data", 32'(last_data), 32'h5A);

        // Overrun: consumer stalled across two bytes.
        ready_i = 1'b0;
        o0 = n_ovr; f0 = n_ferr;
        idle(4);
        send_frame(8'h11, 16, 1'b0, 2'b00);
        idle(4);
        send_frame(8'h22, 16, 1'b0, 2'b00);
        idle(4);
        check("overrun valid held", 32'(valid_o), 32'h1);
        check("overrun data held", 32'(rx_data_o), 32'h11);
        check("overrun pulses", 32'(n_ovr - o0), 32'h1);
        check("overrun frame_err pulses", 32'(n_ferr - f0), 32'h0);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("overrun valid after ready", 32'(valid_o), 32'h0);
        check("overrun consumed data", 32'(last_data), 32'h11);
        idle(4);
        check("overrun no new valid", 32'(valid_o), 32'h0);

        // Reset during data bit 3 of 0x81.
        baud_div_i    = 16'd16;
        two_stop_bits = 1'b0;
        v0 = n_valid;
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b0, 16);
        send_bit(1'b0, 8);
        rst_n = 1'b0;
        #2;
        check("midreset rx_data_o", 32'(rx_data_o), 32'h0);
        check("midreset valid_o", 32'(valid_o), 32'h0);
        check("midreset frame_err_o", 32'(frame_err_o), 32'h0);
        check("midreset overrun_o", 32'(overrun_o), 32'h0);
        rx_pin_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(30);
        check("midreset no spurious valid", 32'(n_valid - v0), 32'h0);
        f0 = n_ferr;
        send_frame(8'h81, 16, 1'b0, 2'b00);
        idle(4);
        check("post-reset valid cycles", 32'(n_valid - v0), 32'h1);
        check("post-reset data", 32'(last_data), 32'h81);
        check("post-reset frame_err pulses", 32'(n_ferr - f0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
